// File: rtl/relu_pkg.sv
// Shared types and helpers for the ReLU6 backward-pass mask path.
package relu_pkg;

  typedef struct packed {
    logic last;
    logic pass;
  } mask_entry_t;

  function automatic longint fxp_threshold(input int threshold, input int fxp_frac,
                                           input int width);
    longint v;
    v = longint'(threshold) <<< fxp_frac;
    if (width < 64) v = v & ((64'sd1 <<< width) - 64'sd1);
    return v;
  endfunction

endpackage

// File: rtl/mask_fifo.sv
// In-order FIFO of derivative mask entries with synchronous flush.
module mask_fifo
  import relu_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  mask_entry_t            push_data,
  input  logic                   pop,
  output mask_entry_t            pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  mask_entry_t     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/relu6_backward.sv
// ReLU6 backward pass: records forward derivative masks and gates the gradient stream.
module relu6_backward
  import relu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int THRESHOLD = 6,
  parameter int FXP_FRAC  = 15,
  parameter int GRAD_W    = 16,
  parameter int DEPTH     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     fwd_valid,
  output logic                     fwd_ready,
  input  logic signed [WIDTH-1:0]  fwd_in,
  input  logic                     fwd_last,
  input  logic                     grad_valid,
  output logic                     grad_ready,
  input  logic signed [GRAD_W-1:0] grad_in,
  input  logic                     grad_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [GRAD_W-1:0] out_grad,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     sync_err
);

  localparam logic signed [WIDTH-1:0] FXP_TH =
    WIDTH'(fxp_threshold(THRESHOLD, FXP_FRAC, WIDTH));
  localparam logic signed [WIDTH-1:0] ZERO = '0;

  mask_entry_t push_entry;
  mask_entry_t pop_entry;
  logic        full;
  logic        empty;
  logic        push;
  logic        accept;

  // Derivative is zero at and above the clamp ceiling, as well as for x <= 0.
  assign push_entry.pass = (fwd_in > ZERO) && (fwd_in < FXP_TH);
  assign push_entry.last = fwd_last;

  assign fwd_ready  = !full;
  assign push       = fwd_valid && fwd_ready;
  assign grad_ready = !empty && (!out_valid || out_ready);
  assign accept     = grad_valid && grad_ready;

  mask_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (accept),
    .pop_data  (pop_entry),
    .full      (full),
    .empty     (empty),
    .count     (occupancy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_grad  <= '0;
      out_last  <= 1'b0;
      sync_err  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_grad  <= '0;
      out_last  <= 1'b0;
      sync_err  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_grad  <= pop_entry.pass ? grad_in : '0;
      out_last  <= grad_last;
      if (grad_last != pop_entry.last) sync_err <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relu6_backward.sv
// Self-checking bench for relu6_backward against a transaction-level queue model.
module tb_relu6_backward;

  localparam int DEPTH  = 64;
  localparam int FXP_TH = 6 * (1 << 15);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic               fwd_valid;
  logic               fwd_ready;
  logic signed [31:0] fwd_in;
  logic               fwd_last;
  logic               grad_valid;
  logic               grad_ready;
  logic signed [15:0] grad_in;
  logic               grad_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_grad;
  logic               out_last;
  logic [6:0]         occupancy;
  logic               sync_err;

  int checks   = 0;
  int failures = 0;

  // model state: queue of {last, pass}, output register, sticky error
  bit [1:0]        mq[$];
  bit              m_ov;
  int              m_og;
  bit              m_ol;
  bit              m_serr;

  always #5 clk = ~clk;

  relu6_backward dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .fwd_valid  (fwd_valid),
    .fwd_ready  (fwd_ready),
    .fwd_in     (fwd_in),
    .fwd_last   (fwd_last),
    .grad_valid (grad_valid),
    .grad_ready (grad_ready),
    .grad_in    (grad_in),
    .grad_last  (grad_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_grad   (out_grad),
    .out_last   (out_last),
    .occupancy  (occupancy),
    .sync_err   (sync_err)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit ref_pass(input int x);
    return (x > 0) && (x < FXP_TH);
  endfunction

  task automatic idle();
    flush = 0; fwd_valid = 0; fwd_in = 0; fwd_last = 0;
    grad_valid = 0; grad_in = 0; grad_last = 0;
  endtask

  task automatic model_clear();
    mq.delete(); m_ov = 0; m_og = 0; m_ol = 0; m_serr = 0;
  endtask

  // Check current outputs against the model, then advance one clock with both.
  task automatic step();
    bit exp_fr, exp_gr, do_push, do_acc;
    bit [1:0] e;
    #1;
    exp_fr = (mq.size() < DEPTH);
    exp_gr = (mq.size() > 0) && (!m_ov || out_ready);
    check("fwd_ready", fwd_ready, exp_fr);
    check("grad_ready", grad_ready, exp_gr);
    check("occupancy", occupancy, mq.size());
    check("out_valid", out_valid, m_ov);
    check("sync_err", sync_err, m_serr);
    if (m_ov) begin
      check("out_grad", out_grad, m_og);
      check("out_last", out_last, m_ol);
    end
    do_push = fwd_valid && exp_fr;
    do_acc  = grad_valid && exp_gr;
    if (flush) begin
      model_clear();
    end else begin
      if (do_acc) begin
        e = mq.pop_front();
        m_ov = 1;
        m_og = e[0] ? int'(grad_in) : 0;
        m_ol = grad_last;
        if (grad_last != e[1]) m_serr = 1;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (do_push) mq.push_back({fwd_last, ref_pass(int'(fwd_in))});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    idle(); flush = 1; step(); flush = 0;
  endtask

  initial begin
    int bvals[6];
    int bexp[6];
    int held;
    int pick[6];
    bvals = '{-5, 0, 1, 196607, 196608, 300000};
    bexp  = '{0, 0, 100, 100, 0, 0};
    pick  = '{0, 1, -1, 196607, 196608, 196609};

    rst_n = 0; out_ready = 1; idle(); model_clear();
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_grad", out_grad, 0);
    check("rst_out_last", out_last, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_sync_err", sync_err, 0);
    #9 rst_n = 1;
    @(posedge clk); #1;

    // gating boundaries
    for (int i = 0; i < 6; i++) begin
      fwd_valid = 1; fwd_in = bvals[i]; step();
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      grad_valid = 1; grad_in = 100; step();
      check($sformatf("bound_grad%0d", i), out_grad, bexp[i]);
      check($sformatf("bound_valid%0d", i), out_valid, 1);
    end
    idle(); step();

    // full FIFO
    do_flush();
    for (int i = 0; i < DEPTH; i++) begin
      fwd_valid = 1; fwd_in = i * 1000; step();
    end
    check("full_occ", occupancy, 64);
    check("full_fwd_ready", fwd_ready, 0);
    fwd_in = 12345; step();
    check("full_stall_occ", occupancy, 64);
    grad_valid = 1; grad_in = 7; step();
    grad_valid = 0;
    check("full_after_pop_ready", fwd_ready, 1);
    check("full_after_pop_occ", occupancy, 63);
    step();
    check("full_65th_occ", occupancy, 64);
    idle();

    // backpressure
    do_flush();
    for (int i = 0; i < 4; i++) begin
      fwd_valid = 1; fwd_in = 1000 + i; step();
    end
    idle();
    out_ready = 0; grad_valid = 1; grad_in = 321; step();
    held = int'(out_grad);
    check("bp_first_grad", held, 321);
    for (int i = 0; i < 5; i++) begin
      grad_in = 16'(i + 1); step();
      check("bp_hold_grad", out_grad, held);
      check("bp_grad_ready", grad_ready, 0);
      check("bp_occ", occupancy, 3);
    end
    out_ready = 1; step();
    check("bp_release_occ", occupancy, 2);
    idle(); step(); step(); step();

    // last mismatch
    do_flush();
    for (int i = 1; i <= 5; i++) begin
      fwd_valid = 1; fwd_in = 5000; fwd_last = (i == 3); step();
    end
    idle();
    for (int i = 1; i <= 5; i++) begin
      grad_valid = 1; grad_in = 16'(i); grad_last = (i == 4); step();
      if (i == 3) check("last_err_set", sync_err, 1);
      if (i == 4) check("last_err_sticky", sync_err, 1);
    end
    idle(); step();
    do_flush();
    check("last_err_flushed", sync_err, 0);

    // empty / no bypass
    grad_valid = 1; grad_in = 55;
    #1 check("empty_grad_ready", grad_ready, 0);
    step();
    fwd_valid = 1; fwd_in = 77; step();
    fwd_valid = 0;
    check("nobypass_ready_n1", grad_ready, 1);
    check("nobypass_valid_n1", out_valid, 0);
    step();
    check("nobypass_valid_n2", out_valid, 1);
    check("nobypass_grad_n2", out_grad, 55);
    idle(); step();

    // async reset mid-stream
    do_flush();
    for (int i = 0; i < 11; i++) begin
      fwd_valid = 1; fwd_in = 2000; step();
    end
    idle(); out_ready = 0; grad_valid = 1; grad_in = 9; step();
    check("mid_occ", occupancy, 10);
    check("mid_valid", out_valid, 1);
    idle();
    #2 rst_n = 0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_occ", occupancy, 0);
    check("async_rst_grad", out_grad, 0);
    model_clear();
    #2 rst_n = 1;
    @(posedge clk); #1;
    out_ready = 1; step();

    // flush mid-stream
    for (int i = 0; i < 11; i++) begin
      fwd_valid = 1; fwd_in = 2000; step();
    end
    idle(); out_ready = 0; grad_valid = 1; grad_in = 9; step();
    check("mid2_valid", out_valid, 1);
    flush = 1; step(); flush = 0;
    check("flush_occ", occupancy, 0);
    check("flush_valid", out_valid, 0);
    idle(); out_ready = 1; step();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      flush      = ($urandom_range(0, 99) == 0);
      fwd_valid  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       fwd_in = pick[$urandom_range(0, 5)];
        1:       fwd_in = $urandom;
        default: fwd_in = $urandom_range(0, 400000) - 100000;
      endcase
      fwd_last   = ($urandom_range(0, 7) == 0);
      grad_valid = ($urandom_range(0, 2) != 0);
      grad_in    = 16'($urandom);
      grad_last  = ($urandom_range(0, 7) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    idle(); out_ready = 1; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/relu6_backward.md
Name: relu6_backward

Overview:
Backward-pass companion to the forward ReLU6 activation stage. Records a one-bit derivative mask per element from the forward pre-activation stream (Q.FXP_FRAC fixed point) into an in-order mask FIFO. Later gates the incoming gradient stream with those masks: gradient passes where 0 < x < THRESHOLD and is zeroed elsewhere. Sits between the forward activation output and the previous layer's gradient path, with valid/ready handshakes on all three streams.

Parameters:
WIDTH, 32, pre-activation width (signed, Q.FXP_FRAC)
THRESHOLD, 6, clamp ceiling in integer units
FXP_FRAC, 15, fractional bits of pre-activation
GRAD_W, 16, gradient width (signed)
DEPTH, 64, mask FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of FIFO, output register, sync_err
fwd_valid  in  1  forward element valid
fwd_ready  out  1  forward element accepted when high with fwd_valid
fwd_in  in  WIDTH  signed pre-activation value
fwd_last  in  1  last element of a layer/tile
grad_valid  in  1  gradient element valid
grad_ready  out  1  gradient accepted when high with grad_valid
grad_in  in  GRAD_W  signed upstream gradient
grad_last  in  1  last gradient of a layer/tile
out_valid  out  1  gated gradient valid
out_ready  in  1  downstream accepts
out_grad  out  GRAD_W  gated gradient
out_last  out  1  registered grad_last
occupancy  out  $clog2(DEPTH)+1  FIFO entry count
sync_err  out  1  sticky last-flag mismatch

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_grad=0, out_last=0, occupancy=0, sync_err=0, FIFO pointers=0.
- Threshold constant: FXP_TH = THRESHOLD << FXP_FRAC, sized WIDTH signed (default 196608).
- pass = (fwd_in > 0) && (fwd_in < FXP_TH). The comparison is signed. fwd_in==0 gives 0. fwd_in==FXP_TH gives 0 because the derivative is 0 in saturation.
- Mask entry = {fwd_last, pass}.
- Push when fwd_valid && fwd_ready. fwd_ready = !full, based on the current count only. A pop in the same cycle does not free a slot for that cycle's push.
- grad_ready = !empty && (!out_valid || out_ready). There is no same-cycle bypass: a mask pushed in cycle N is poppable in N+1 at the earliest.
- Accept (grad_valid && grad_ready) does three things:
  - pops one entry;
  - loads the output register next edge with out_grad = pass ? grad_in : 0, out_last = grad_last, out_valid = 1;
  - sets sync_err if grad_last != stored last (sticky).
- Latency from grad accept to out_valid is 1 cycle. Full throughput is 1 element/cycle under out_ready=1.
- Output hold: while out_valid && !out_ready, out_grad and out_last stay stable and no pop occurs. out_valid clears when out_ready is high and there is no new accept.
- Simultaneous push and pop: occupancy unchanged. Pointers wrap modulo DEPTH.
- flush has priority over push, pop and load that cycle. Next cycle: occupancy=0, out_valid=0, sync_err=0. fwd_ready goes high. grad_ready goes low.
- Reset mid-operation: in-flight data is discarded. No partial state survives.

Decomposition:
- Package relu_pkg: function fxp_threshold(THRESHOLD, FXP_FRAC, WIDTH); typedef packed struct mask_entry_t {logic last; logic pass;}.
- Sub-module mask_fifo: synchronous FIFO of mask_entry_t, DEPTH entries, with push/pop/full/empty/count and flush. This block instantiates it and adds the compare logic and output register.

Test Plan:
- Gating boundaries: fwd_in = -5, 0, 1, 196607, 196608, 300000, then grad_in=100 ×6 with out_ready=1 -> out_grad = 0, 0, 100, 100, 0, 0, each 1 cycle after its accept.
- Full FIFO: push 64 with no grads -> occupancy=64, fwd_ready=0, and the 65th element stalls. One grad accept -> fwd_ready=1 the next cycle, and the 65th is pushed.
- Backpressure: out_ready=0 for 5 cycles with grad_valid=1 and occupancy 3 -> out_grad held constant, grad_ready=0, occupancy stays 3 until out_ready=1.
- Last mismatch: fwd_last on element 3, grad_last on element 4 -> sync_err=1 after element 3's accept and remains 1 through element 4. flush -> sync_err=0.
- Empty/no bypass: grad_valid=1 with an empty FIFO -> grad_ready=0. A push in cycle N -> grad accepted in N+1 and out_valid in N+2.
- Reset/flush mid-stream: occupancy=10 with out_valid=1. Drop rst_n asynchronously -> outputs zero immediately. Separately, pulse flush -> occupancy=0 and out_valid=0 next edge.
